// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: register-array memory with byte/halfword/word writes and ERROR responses.
// Latency: OKAY completes WAIT_STATES+1 cycles after address accept; ERROR completes 2 cycles after.
// Backpressure: hreadyout held low during wait states and ERR1; new beats accepted only while hreadyout=1.
//
// Ports:
//   hclk, hreset_n          clock, synchronous active-low reset
//   hsel, hreadyin          slave select and bus-level HREADY
//   haddr, htrans, hwrite,  address-phase controls
//   hsize, hburst
//   hwdata                  write data (data phase)
//   hreadyout, hrdata,      data-phase response
//   hresp
module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hreset_n,
    input  logic        hsel,
    input  logic        hreadyin,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic [31:0] hrdata,
    output logic        hresp
);

    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       lane_q, lane_d;
    logic [1:0]       size_q, size_d;
    logic             write_q, write_d;

    logic [31:0]      mem [MEM_DEPTH];

    logic [31:0]      offset;
    logic             slot_open;
    logic             accept;
    logic             addr_err;
    logic             mem_we;
    logic [3:0]       byte_en;

    // Burst type carries no meaning here: every beat stands on its own.
    logic             unused_hburst;
    assign unused_hburst = ^hburst;

    // A new address phase can only land when the current data phase is finishing
    // (or nothing is in flight), i.e. whenever this slave drives hreadyout high.
    assign slot_open = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign accept    = slot_open && hsel && hreadyin && htrans[1];

    // Offset wraps for addresses below the base, so one compare covers both ends.
    assign offset   = haddr - BASE_ADDR;
    assign addr_err = (hsize > 3'b010)
                   || ((hsize == 3'b001) && haddr[0])
                   || ((hsize == 3'b010) && (haddr[1:0] != 2'b00))
                   || ({1'b0, offset} >= MEM_BYTES);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        size_d     = size_q;
        write_d    = write_q;

        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: state_d = ST_IDLE;
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        // A beat accepted alongside a completing one is decided as if from IDLE.
        if (accept) begin
            idx_d   = offset[IDX_W+1:2];
            lane_d  = haddr[1:0];
            size_d  = hsize[1:0];
            write_d = hwrite;
            if (addr_err) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES != 0) begin
                state_d    = ST_WAIT;
                wait_cnt_d = 4'(WAIT_STATES - 1);
            end else begin
                state_d = ST_DATA;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            idx_q      <= '0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            write_q    <= write_d;
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            2'b00:   byte_en = 4'b0001 << lane_q;
            2'b01:   byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Gating with hreset_n drops a write whose DATA cycle collides with reset.
    assign mem_we = hreset_n && write_q && (state_q == ST_DATA);

    // Memory contents survive reset.
    always_ff @(posedge hclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    assign hreadyout = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    // A write that just landed is visible to a read in the very next DATA cycle.
    assign hrdata    = ((state_q == ST_DATA) && !write_q) ? mem[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

    localparam logic [31:0] BASE   = 32'h0000_4000;
    localparam int          DEPTH  = 64;
    localparam int          NBYTES = 4 * DEPTH;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] rdata;
        int          nwait;
    } exp_t;

    logic             hclk;
    logic             hreset_n;
    logic [1:0]       hsel;
    logic [1:0][31:0] haddr;
    logic [1:0][1:0]  htrans;
    logic [1:0]       hwrite;
    logic [1:0][2:0]  hsize;
    logic [1:0][2:0]  hburst;
    logic [1:0][31:0] hwdata;
    logic [1:0]       hreadyout;
    logic [1:0][31:0] hrdata;
    logic [1:0]       hresp;

    int nchecks = 0;
    int nerr    = 0;

    logic [7:0] mb [2][NBYTES];
    exp_t       q0[$];
    exp_t       q1[$];
    beat_t      bq[$];

    ahb_sram_slave #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(1)) u_dut0 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel[0]), .hreadyin(hreadyout[0]),
        .haddr(haddr[0]), .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]),
        .hburst(hburst[0]), .hwdata(hwdata[0]), .hreadyout(hreadyout[0]),
        .hrdata(hrdata[0]), .hresp(hresp[0]));

    ahb_sram_slave #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut1 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel[1]), .hreadyin(hreadyout[1]),
        .haddr(haddr[1]), .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]),
        .hburst(hburst[1]), .hwdata(hwdata[1]), .hreadyout(hreadyout[1]),
        .hrdata(hrdata[1]), .hresp(hresp[1]));

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    function automatic void check(int d, string name, logic [31:0] act, logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL dut%0d %s: got %h expected %h", d, name, act, exp);
        end
    endfunction

    function automatic beat_t mk(logic sel, logic [1:0] trans, logic [31:0] addr,
                                 logic wr, logic [2:0] size, logic [31:0] wdata);
        beat_t b;
        b.sel = sel; b.trans = trans; b.addr = addr;
        b.wr = wr; b.size = size; b.wdata = wdata;
        return b;
    endfunction

    function automatic void push_exp(int d, exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    // Reference: byte-addressed memory; a read returns the whole aligned word.
    function automatic void issue(int d, beat_t b, bit apply);
        exp_t   e;
        longint off;
        int     wbase;
        off     = longint'(b.addr) - longint'(BASE);
        e.err   = (b.size > 3'd2)
               || ((b.size == 3'd1) && b.addr[0])
               || ((b.size == 3'd2) && (b.addr[1:0] != 2'b00))
               || (off < 0) || (off >= longint'(NBYTES));
        e.rd    = !b.wr;
        e.nwait = e.err ? 1 : ((d == 0) ? 1 : 0);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (b.wr && apply) begin
                for (int k = 0; k < (1 << b.size); k++) begin
                    int o;
                    o = int'(off) + k;
                    mb[d][o] = b.wdata[8*(o%4) +: 8];
                end
            end
            wbase   = int'(off) & ~3;
            e.rdata = {mb[d][wbase+3], mb[d][wbase+2], mb[d][wbase+1], mb[d][wbase]};
        end
        push_exp(d, e);
    endfunction

    task automatic monitor(input int d);
        exp_t cur;
        bit   act = 0;
        int   cyc = 0;
        bit   last;
        forever begin
            @(negedge hclk);
            if (!hreset_n) begin
                act = 0;
                if (d == 0) q0.delete();
                else        q1.delete();
                continue;
            end
            if (act) begin
                last = (cyc >= cur.nwait);
                check(d, "hreadyout", 32'(hreadyout[d]), 32'(last));
                check(d, "hresp", 32'(hresp[d]), 32'(cur.err));
                check(d, "hrdata", hrdata[d], (last && cur.rd && !cur.err) ? cur.rdata : 32'h0);
                cyc++;
                if (last) act = 0;
            end else begin
                check(d, "idle_hreadyout", 32'(hreadyout[d]), 32'h1);
                check(d, "idle_hresp", 32'(hresp[d]), 32'h0);
                check(d, "idle_hrdata", hrdata[d], 32'h0);
            end
            if (hsel[d] && htrans[d][1] && hreadyout[d]) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    nchecks++; nerr++;
                    $display("FAIL dut%0d accept: got beat with no expected response, required queued entry", d);
                end else begin
                    cur = (d == 0) ? q0.pop_front() : q1.pop_front();
                    act = 1;
                    cyc = 0;
                end
            end
        end
    endtask

    // Pipelined master: entered and left just after a rising edge.
    task automatic run(input int d);
        beat_t       b;
        bit          addr_pend = 0;
        bit          data_pend = 0;
        logic [31:0] data_wd   = 32'h0;
        logic        rdy;
        int          guard     = 0;
        while (bq.size() > 0 || addr_pend || data_pend) begin
            if (!addr_pend && bq.size() > 0) begin
                b         = bq.pop_front();
                addr_pend = 1;
                hsel[d]   = b.sel;
                htrans[d] = b.trans;
                haddr[d]  = b.addr;
                hwrite[d] = b.wr;
                hsize[d]  = b.size;
                hburst[d] = 3'($urandom_range(0, 7));
                if (b.sel && b.trans[1]) issue(d, b, 1'b1);
            end else if (!addr_pend) begin
                hsel[d]   = 1'b0;
                htrans[d] = 2'b00;
            end
            hwdata[d] = data_pend ? data_wd : $urandom;
            @(negedge hclk);
            rdy = hreadyout[d];
            @(posedge hclk);
            #1;
            guard++;
            if (guard > 2000) begin
                nchecks++; nerr++;
                $display("FAIL dut%0d timeout: got %0d cycles without draining, required fewer", d, guard);
                bq.delete();
                break;
            end
            if (rdy) begin
                data_pend = addr_pend && b.sel && b.trans[1];
                data_wd   = b.wdata;
                addr_pend = 0;
            end
        end
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        int    r;
        int    sz;
        r  = int'($urandom_range(0, 99));
        sz = int'($urandom_range(0, 2));
        b  = mk(1'b1, 2'b10 | 2'($urandom_range(0, 1)),
                BASE + 32'(int'($urandom_range(0, NBYTES-1)) & ~((1 << sz) - 1)),
                1'($urandom_range(0, 1)), 3'(sz), $urandom);
        if (r < 8) begin
            b.sel   = 1'($urandom_range(0, 1));
            b.trans = b.sel ? 2'($urandom_range(0, 1)) : 2'b10;
        end else if (r < 14) begin
            b.size = 3'($urandom_range(3, 7));
        end else if (r < 20) begin
            b.addr = b.addr | 32'h1;
        end else if (r < 23) begin
            b.addr = BASE + 32'(NBYTES) + 32'(4 * $urandom_range(0, 60));
        end else if (r < 26) begin
            b.addr = BASE - 32'(4 * $urandom_range(1, 8));
        end
        return b;
    endfunction

    initial begin
        hreset_n = 1'b0;
        hsel = '0; htrans = '0; haddr = '0; hwrite = '0;
        hsize = '0; hburst = '0; hwdata = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NBYTES; i++) mb[d][i] = 8'h0;
        fork
            monitor(0);
            monitor(1);
        join_none
        repeat (3) @(posedge hclk);
        #1 hreset_n = 1'b1;

        // Give every word a known value.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++)
                bq.push_back(mk(1'b1, 2'b10, BASE + 32'(4*w), 1'b1, 3'd2, $urandom));
            run(d);
        end

        // Word write then read back with one wait state.
        bq.push_back(mk(1'b1, 2'b10, BASE + 32'h10, 1'b1, 3'd2, 32'hDEADBEEF));
        bq.push_back(mk(1'b1, 2'b10, BASE + 32'h10, 1'b0, 3'd2, 32'h0));
        run(0);

        // Byte lanes assembled into one word.
        for (int k = 0; k < 4; k++)
            bq.push_back(mk(1'b1, 2'b10, BASE + 32'h20 + 32'(k), 1'b1, 3'd0,
                            $urandom & ~(32'hFF << (8*k)) | (32'(8'h11 * (k+1)) << (8*k))));
        bq.push_back(mk(1'b1, 2'b10, BASE + 32'h20, 1'b0, 3'd2, 32'h0));
        bq.push_back(mk(1'b1, 2'b10, BASE + 32'h24, 1'b1, 3'd1, 32'h1234_ABCD));
        bq.push_back(mk(1'b1, 2'b10, BASE + 32'h26, 1'b1, 3'd1, 32'h5678_9999));
        bq.push_back(mk(1'b1, 2'b10, BASE + 32'h24, 1'b0, 3'd2, 32'h0));
        run(0);

        // Zero-wait INCR4 write then read burst.
        for (int k = 0; k < 4; k++)
            bq.push_back(mk(1'b1, (k == 0) ? 2'b10 : 2'b11, BASE + 32'h30 + 32'(4*k),
                            1'b1, 3'd2, 32'(k+1)));
        for (int k = 0; k < 4; k++)
            bq.push_back(mk(1'b1, (k == 0) ? 2'b10 : 2'b11, BASE + 32'h30 + 32'(4*k),
                            1'b0, 3'd2, 32'h0));
        run(1);

        // Error responses leave memory alone.
        for (int d = 0; d < 2; d++) begin
            bq.push_back(mk(1'b1, 2'b10, BASE + 32'h2, 1'b0, 3'd2, 32'h0));
            bq.push_back(mk(1'b1, 2'b10, BASE + 32'(NBYTES), 1'b0, 3'd2, 32'h0));
            bq.push_back(mk(1'b1, 2'b10, BASE + 32'h2, 1'b1, 3'd2, 32'hFFFF_FFFF));
            bq.push_back(mk(1'b1, 2'b11, BASE - 32'h4, 1'b1, 3'd2, 32'hFFFF_FFFF));
            bq.push_back(mk(1'b1, 2'b11, BASE + 32'h8, 1'b1, 3'd3, 32'hFFFF_FFFF));
            bq.push_back(mk(1'b1, 2'b10, BASE, 1'b0, 3'd2, 32'h0));
            bq.push_back(mk(1'b1, 2'b10, BASE + 32'h8, 1'b0, 3'd2, 32'h0));
            run(d);
        end

        // Write immediately followed by read of the same word.
        for (int d = 0; d < 2; d++) begin
            bq.push_back(mk(1'b1, 2'b10, BASE + 32'h44, 1'b1, 3'd2, 32'hCAFE_F00D));
            bq.push_back(mk(1'b1, 2'b10, BASE + 32'h44, 1'b0, 3'd2, 32'h0));
            bq.push_back(mk(1'b1, 2'b10, BASE + 32'h45, 1'b1, 3'd0, 32'h0000_7700));
            bq.push_back(mk(1'b1, 2'b11, BASE + 32'h44, 1'b0, 3'd2, 32'h0));
            run(d);
        end

        // Reset during the wait state of a write aborts it.
        haddr[0]  = BASE + 32'h40;
        hsel[0]   = 1'b1;
        htrans[0] = 2'b10;
        hwrite[0] = 1'b1;
        hsize[0]  = 3'd2;
        issue(0, mk(1'b1, 2'b10, BASE + 32'h40, 1'b1, 3'd2, 32'hA5A5_5A5A), 1'b0);
        @(posedge hclk);
        #1;
        hsel[0]   = 1'b0;
        htrans[0] = 2'b00;
        hwdata[0] = 32'hA5A5_5A5A;
        hreset_n  = 1'b0;
        @(posedge hclk);
        #1;
        hreset_n  = 1'b1;
        bq.push_back(mk(1'b1, 2'b10, BASE + 32'h40, 1'b0, 3'd2, 32'h0));
        run(0);

        // Randomised traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 250; i++) bq.push_back(rand_beat());
            run(d);
        end

        repeat (3) @(posedge hclk);
        check(0, "queue_drained", 32'(q0.size()), 32'h0);
        check(1, "queue_drained", 32'(q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
